// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: compares the last PAT_W valid bits against PATTERN.
// Optional per-position don't-care mask enabled by defining SEQ_DETECT_MASK_EN.
module seq_detect_param #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8,
  localparam int                RS_W    = $clog2(PAT_W+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             clear,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [PAT_W-1:0] mask,
`endif
  output logic             os,
  output logic [RS_W-1:0]  rs,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [RS_W-1:0]  RS_MAX  = RS_W'(PAT_W);
  localparam logic [RS_W-1:0]  RS_THR  = RS_W'(PAT_W-1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] sh, sh_n, nxt;
  logic [RS_W-1:0]  rs_n;
  logic [CNT_W-1:0] cnt_n;
  logic             os_n, eq, hit;

  assign nxt = {sh[PAT_W-2:0], din};

`ifdef SEQ_DETECT_MASK_EN
  assign eq = (((nxt ^ PATTERN) & ~mask) == '0);
`else
  assign eq = (nxt == PATTERN);
`endif

  // rs qualification keeps stale history (after reset or a non-overlap restart) from matching
  assign hit = din_valid & eq & (rs >= RS_THR);

  always_comb begin
    sh_n  = sh;
    rs_n  = rs;
    cnt_n = match_cnt;
    os_n  = 1'b0;
    if (clear) begin
      sh_n  = '0;
      rs_n  = '0;
      cnt_n = '0;
    end else if (din_valid) begin
      sh_n = nxt;
      if (hit) begin
        os_n  = 1'b1;
        cnt_n = (match_cnt == CNT_MAX) ? CNT_MAX : match_cnt + CNT_W'(1);
        rs_n  = overlap ? RS_MAX : '0;
      end else begin
        rs_n  = (rs == RS_MAX) ? RS_MAX : rs + RS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh        <= '0;
      rs        <= '0;
      os        <= 1'b0;
      match_cnt <= '0;
    end else begin
      sh        <= sh_n;
      rs        <= rs_n;
      os        <= os_n;
      match_cnt <= cnt_n;
    end
  end

endmodule
